line_window_buf: RTL and testbench
==================================

# line_window_buf

Parametrised raster line buffer for the LBM stencil datapath. It accepts one cell word per valid cycle in raster order and presents ROWS vertically aligned taps, the same column from the current line and the previous ROWS-1 lines. It also tracks column and line position, so downstream stencil logic receives a qualified window with edge flags instead of raw delayed words. It sits between the cell-state source and the collision/streaming stage, and it generalises the fixed 3-line, always-shifting line buffer with a handshake, a line depth set by parameter, frame restart and fill tracking.

## Interface
- SCREEN_WIDTH, 8, cells per line; must be ≥2.
- N_BITS, 15, word width per cell.
- ROWS, 3, number of vertical taps; must be ≥2.
- CW (localparam), $clog2(SCREEN_WIDTH), column counter width.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- d  in  N_BITS  input cell word.
- in_valid  in  1  active-high; d is accepted on every edge where in_valid=1. There is no backpressure.
- sof  in  1  start of frame; meaningful only when in_valid=1.
- tap_out  out  ROWS*N_BITS  slice k (bits k*N_BITS +: N_BITS) is the word accepted exactly k lines before the current sample; slice 0 is the current sample.
- out_valid  out  1  window qualified: all ROWS taps hold data from the current frame.
- out_col  out  CW  column index of the slice-0 sample.
- out_first_col  out  1  out_col==0.
- out_last_col  out  1  out_col==SCREEN_WIDTH-1.

## Operation
- Storage is a word shift array of depth (ROWS-1)*SCREEN_WIDTH+1.
  - Entry 0 is the newest word.
  - Tap k equals entry k*SCREEN_WIDTH.
  - The array advances only on accepted samples.
- Column counter col (CW bits) and fill counter lines (saturating at ROWS-1):
  - On an accepted sample with col==SCREEN_WIDTH-1: col wraps to 0 and lines increments, saturating at ROWS-1.
  - On any other accepted sample: col increments.
- sof handling:
  - An accepted sample with sof=1 is treated as column 0 of line 0.
  - col is forced so that this sample's out_col=0; lines restarts at 0.
  - Array contents are not cleared. Stale taps are masked through out_valid.
  - sof=1 with in_valid=0 is ignored.
- Qualification: out_valid is set for a sample when lines==ROWS-1 at acceptance (line index ≥ ROWS-1 within the frame), otherwise 0.
- The position outputs out_col, out_first_col and out_last_col always describe the most recently accepted sample, whether or not out_valid is set.
- in_valid=0:
  - The array, counters, tap_out and the out_col flags hold.
  - out_valid drops to 0 for that cycle. It is a per-sample pulse, never held.
- Reset (reset=0 at an edge):
  - The whole array is cleared to 0, so tap_out=0.
  - col=0, lines=0, out_valid=0, out_col=0, out_first_col=0, out_last_col=0.
  - Reset overrides in_valid and sof on the same edge.
- Reset asserted mid-frame discards all fill. The first accepted sample after reset is column 0, line 0, whether or not sof is set.

## Timing
- All outputs are registered.
- Latency is 1 cycle: a sample accepted at edge N appears in tap_out slice 0, with its out_col and out_valid, from edge N until the next accepted sample.
- Continuous streaming delivers one window per cycle. The first out_valid comes on the (ROWS-1)*SCREEN_WIDTH+1-th accepted sample of a frame.
- out_valid=1 for exactly one cycle per accepted qualified sample.
- A line wrap and sof on the same accepted sample: sof wins, giving col=0 and lines=0.

## Test plan
- Reset check (W=8, ROWS=3, N_BITS=15): hold reset=0 for 2 cycles, release -> all outputs 0; an idle bus keeps out_valid=0.
- Continuous fill: stream d=0..23 with in_valid=1 and sof=1 on d=0.
  - out_valid=0 for d=0..15.
  - At d=16: out_valid=1, taps {16,8,0}, out_col=0, out_first_col=1.
  - At d=23: taps {23,15,7}, out_last_col=1.
- Gapped input: same stream with in_valid toggled every other cycle -> identical tap/col sequence per accepted sample; out_valid=0 on every idle cycle; taps hold during gaps.
- Mid-frame sof: after the 20th sample, present d=100 with sof=1.
  - out_col=0 and out_valid=0.
  - out_valid stays 0 until 16 more samples are accepted.
  - Then taps {116,108,100}.
- Reset mid-operation: drive reset=0 at sample 18 while in_valid=1 -> next edge has all outputs 0. The following 17 samples without sof: out_valid first rises on the 17th, out_col=0.
- Parameter sweep: W=4, ROWS=5, N_BITS=8, stream d=0..31 -> first out_valid at d=16 with taps {16,12,8,4,0}; the valid count over the stream is 16.

Source files
------------

// File: rtl/line_window_buf.sv
// line_window_buf: raster line buffer that presents ROWS vertically aligned
// taps (same column, current line and the ROWS-1 lines above it) together
// with the column position of the newest sample and a window-qualified flag.
//
// Handshake: a word on d is accepted on every rising edge where in_valid=1;
// there is no backpressure. sof is only looked at on accepted edges. The
// outputs describe the most recently accepted sample; out_valid is a one-cycle
// pulse per accepted sample whose window lies entirely inside the frame.
module line_window_buf #(
  parameter int SCREEN_WIDTH = 8,
  parameter int N_BITS       = 15,
  parameter int ROWS         = 3,
  localparam int CW          = $clog2(SCREEN_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_BITS-1:0]      d,
  input  logic                   in_valid,
  input  logic                   sof,
  output logic [ROWS*N_BITS-1:0] tap_out,
  output logic                   out_valid,
  output logic [CW-1:0]          out_col,
  output logic                   out_first_col,
  output logic                   out_last_col
);

  localparam int DEPTH = (ROWS - 1) * SCREEN_WIDTH + 1;
  localparam int LW    = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL   = CW'(SCREEN_WIDTH - 1);
  localparam logic [LW-1:0] FULL_LINES = LW'(ROWS - 1);

  // Word shift array; entry 0 is the newest accepted word.
  logic [N_BITS-1:0] arr_q [DEPTH];
  logic [N_BITS-1:0] arr_d [DEPTH];

  // col_q is the column the next accepted sample will occupy;
  // lines_q is how many complete lines of the frame precede it (saturating).
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] lines_q, lines_d;

  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          first_q, first_d;
  logic          last_q, last_d;

  // Position of the sample being accepted: sof restarts the frame at col 0, line 0.
  logic [CW-1:0] sample_col;
  logic [LW-1:0] sample_lines;
  assign sample_col   = sof ? '0 : col_q;
  assign sample_lines = sof ? '0 : lines_q;

  // Next-state: shift and advance counters only on accepted samples.
  always_comb begin
    arr_d       = arr_q;
    col_d       = col_q;
    lines_d     = lines_q;
    out_valid_d = 1'b0;
    out_col_d   = out_col_q;
    first_d     = first_q;
    last_d      = last_q;
    if (in_valid) begin
      arr_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        arr_d[i] = arr_q[i-1];
      end
      out_col_d   = sample_col;
      out_valid_d = (sample_lines == FULL_LINES);
      first_d     = (sample_col == '0);
      last_d      = (sample_col == LAST_COL);
      if (sample_col == LAST_COL) begin
        col_d   = '0;
        lines_d = (sample_lines == FULL_LINES) ? sample_lines : sample_lines + LW'(1);
      end else begin
        col_d   = sample_col + CW'(1);
        lines_d = sample_lines;
      end
    end
  end

  // State registers with synchronous active-low reset clearing the whole array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        arr_q[i] <= '0;
      end
      col_q       <= '0;
      lines_q     <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        arr_q[i] <= arr_d[i];
      end
      col_q       <= col_d;
      lines_q     <= lines_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  // Tap k is the word accepted exactly k lines ago.
  for (genvar k = 0; k < ROWS; k++) begin : g_tap
    assign tap_out[k*N_BITS +: N_BITS] = arr_q[k*SCREEN_WIDTH];
  end

  assign out_valid     = out_valid_q;
  assign out_col       = out_col_q;
  assign out_first_col = first_q;
  assign out_last_col  = last_q;

endmodule

// File: tb/tb_line_window_buf.sv
// Bench for line_window_buf: two instances (8x3x15 and 4x5x8) share the
// control stream; a history-queue model predicts every output each cycle.
module tb_line_window_buf;

  localparam int WA = 8, NA = 15, RA = 3;
  localparam int WB = 4, NB = 8,  RB = 5;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic [14:0]   d = '0;
  logic          in_valid = 1'b0;
  logic          sof = 1'b0;
  logic [7:0]    d_b;
  assign d_b = d[7:0];

  logic [RA*NA-1:0] tap_a;
  logic             valid_a, first_a, last_a;
  logic [2:0]       col_a;
  logic [RB*NB-1:0] tap_b;
  logic             valid_b, first_b, last_b;
  logic [1:0]       col_b;

  line_window_buf #(.SCREEN_WIDTH(WA), .N_BITS(NA), .ROWS(RA)) dut_a (
    .clk(clk), .reset(reset), .d(d), .in_valid(in_valid), .sof(sof),
    .tap_out(tap_a), .out_valid(valid_a), .out_col(col_a),
    .out_first_col(first_a), .out_last_col(last_a)
  );

  line_window_buf #(.SCREEN_WIDTH(WB), .N_BITS(NB), .ROWS(RB)) dut_b (
    .clk(clk), .reset(reset), .d(d_b), .in_valid(in_valid), .sof(sof),
    .tap_out(tap_b), .out_valid(valid_b), .out_col(col_b),
    .out_first_col(first_b), .out_last_col(last_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard: history of accepted words (newest first) plus frame sample index.
  logic [NA-1:0]    exp_q_a[$];
  logic [NB-1:0]    exp_q_b[$];
  int               pa, pb;
  logic [RA*NA-1:0] ea_taps;
  logic [RB*NB-1:0] eb_taps;
  logic             ea_valid, ea_first, ea_last;
  logic             eb_valid, eb_first, eb_last;
  int               ea_col, eb_col;
  logic             model_live = 1'b0;

  // Reference model: tap k = word accepted k*W samples ago (0 if cleared);
  // column = frame index mod W; qualified once frame index / W >= ROWS-1.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      exp_q_a.delete(); exp_q_b.delete();
      pa = 0; pb = 0;
      ea_taps = '0; ea_valid = 0; ea_first = 0; ea_last = 0; ea_col = 0;
      eb_taps = '0; eb_valid = 0; eb_first = 0; eb_last = 0; eb_col = 0;
      model_live = 1'b1;
    end else if (in_valid) begin
      if (sof) begin
        pa = 0; pb = 0;
      end
      exp_q_a.push_front(d);
      exp_q_b.push_front(d_b);
      if (exp_q_a.size() > (RA-1)*WA+1) void'(exp_q_a.pop_back());
      if (exp_q_b.size() > (RB-1)*WB+1) void'(exp_q_b.pop_back());
      ea_col = pa % WA; ea_valid = (pa / WA) >= RA-1;
      ea_first = (ea_col == 0); ea_last = (ea_col == WA-1);
      eb_col = pb % WB; eb_valid = (pb / WB) >= RB-1;
      eb_first = (eb_col == 0); eb_last = (eb_col == WB-1);
      for (int k = 0; k < RA; k++)
        ea_taps[k*NA +: NA] = (k*WA < exp_q_a.size()) ? exp_q_a[k*WA] : '0;
      for (int k = 0; k < RB; k++)
        eb_taps[k*NB +: NB] = (k*WB < exp_q_b.size()) ? exp_q_b[k*WB] : '0;
      pa++; pb++;
    end else begin
      ea_valid = 0; eb_valid = 0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_live) begin
      check("a_taps",  64'(tap_a),   64'(ea_taps));
      check("a_valid", 64'(valid_a), 64'(ea_valid));
      check("a_col",   64'(col_a),   64'(ea_col));
      check("a_first", 64'(first_a), 64'(ea_first));
      check("a_last",  64'(last_a),  64'(ea_last));
      check("b_taps",  64'(tap_b),   64'(eb_taps));
      check("b_valid", 64'(valid_b), 64'(eb_valid));
      check("b_col",   64'(col_b),   64'(eb_col));
      check("b_first", 64'(first_b), 64'(eb_first));
      check("b_last",  64'(last_b),  64'(eb_last));
    end
  end

  // Driver: present one cycle of inputs, return just after the edge that takes them.
  task automatic send(input logic v, input logic s, input logic [14:0] x, input logic rst_n);
    @(negedge clk);
    in_valid = v; sof = s; d = x; reset = rst_n;
    @(posedge clk);
    #1;
  endtask

  int cnt_a, cnt_b;

  initial begin
    // Reset check
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);
    check("rst_taps", 64'(tap_a), 64'd0);
    check("rst_outs", 64'({valid_a, col_a, first_a, last_a}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      send(0, 0, 15'($urandom), 1);
      check("idle_valid", 64'(valid_a), 64'd0);
    end

    // Continuous fill d=0..31
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 32; i++) begin
      send(1, i == 0, 15'(i), 1);
      cnt_a += int'(valid_a); cnt_b += int'(valid_b);
      if (i < 16) check("fill_valid", 64'(valid_a), 64'd0);
      if (i == 16) begin
        check("d16_taps_a", 64'(tap_a), 64'({15'd0, 15'd8, 15'd16}));
        check("d16_col_first", 64'({valid_a, col_a, first_a}), 64'({1'b1, 3'd0, 1'b1}));
        check("d16_taps_b", 64'(tap_b), 64'({8'd0, 8'd4, 8'd8, 8'd12, 8'd16}));
        check("d16_valid_b", 64'(valid_b), 64'd1);
      end
      if (i == 23) begin
        check("d23_taps_a", 64'(tap_a), 64'({15'd7, 15'd15, 15'd23}));
        check("d23_last", 64'(last_a), 64'd1);
      end
    end
    check("count_a", 64'(cnt_a), 64'd16);
    check("count_b", 64'(cnt_b), 64'd16);

    // Gapped input
    for (int i = 0; i < 24; i++) begin
      send(1, i == 0, 15'(i), 1);
      send(0, 0, 15'(i + 77), 1);
      check("gap_valid", 64'(valid_a), 64'd0);
      if (i == 16) check("gap_d16_taps", 64'(tap_a), 64'({15'd0, 15'd8, 15'd16}));
    end

    // Mid-frame sof
    for (int i = 0; i < 20; i++) send(1, i == 0, 15'(i), 1);
    send(1, 1, 15'd100, 1);
    check("sof_col_valid", 64'({valid_a, col_a}), 64'd0);
    for (int i = 1; i <= 16; i++) begin
      send(1, 0, 15'(100 + i), 1);
      if (i < 16) check("sof_fill", 64'(valid_a), 64'd0);
    end
    check("sof_taps_a", 64'(tap_a), 64'({15'd100, 15'd108, 15'd116}));
    check("sof_valid_a", 64'(valid_a), 64'd1);
    check("sof_taps_b", 64'(tap_b), 64'({8'd100, 8'd104, 8'd108, 8'd112, 8'd116}));

    // Reset mid-operation
    for (int i = 0; i < 18; i++) send(1, i == 0, 15'(i), 1);
    send(1, 0, 15'd18, 0);
    check("midrst_taps", 64'(tap_a), 64'd0);
    check("midrst_outs", 64'({valid_a, col_a, first_a, last_a}), 64'd0);
    for (int i = 0; i < 17; i++) begin
      send(1, 0, 15'(200 + i), 1);
      if (i < 16) check("midrst_fill", 64'(valid_a), 64'd0);
    end
    check("midrst_valid", 64'({valid_a, col_a}), 64'({1'b1, 3'd0}));
    check("midrst_taps_a", 64'(tap_a), 64'({15'd200, 15'd208, 15'd216}));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      send($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
           15'($urandom), $urandom_range(0, 199) != 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
